// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// ALU ops, mux select codes and instruction field constants.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_LINK   = 4'd9,
    S_BRANCH = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_ORR   = 3'b011,
    ALU_PASSB = 3'b100
  } alu_op_t;

  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10, RES_PC = 2'b11;
  localparam logic [1:0] SRCB_RM = 2'b00, SRCB_IMM = 2'b01, SRCB_4 = 2'b10;
  localparam logic [1:0] IMM8 = 2'b00, IMM12 = 2'b01, IMM24 = 2'b10;

  localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100,
                         CMD_CMP = 4'b1010, CMD_ORR = 4'b1100, CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                         COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                         COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb,
                         COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return cmd inside {CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR, CMD_MOV};
  endfunction

  function automatic alu_op_t cmd_alu_op(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: return ALU_SUB;
      CMD_AND:          return ALU_AND;
      CMD_ORR:          return ALU_ORR;
      CMD_MOV:          return ALU_PASSB;
      default:          return ALU_ADD;
    endcase
  endfunction

  // Logical ops leave C and V untouched when they set flags.
  function automatic logic cmd_is_logic(input logic [3:0] cmd);
    return cmd inside {CMD_AND, CMD_ORR, CMD_MOV};
  endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR word and ALU flags in, selects/enables out.
interface arm_multicycle_ctrl_if;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        pc_write;
  logic        adr_src;
  logic        mem_write;
  logic        ir_write;
  logic [1:0]  result_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_control;
  logic [1:0]  imm_src;
  logic        reg_write;
  logic [1:0]  reg_src;
  logic        link;
  logic [3:0]  state_o;

  modport master (
    input  instr, alu_flags,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_control, imm_src, reg_write, reg_src, link, state_o
  );

  modport slave (
    output instr, alu_flags,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_control, imm_src, reg_write, reg_src, link, state_o
  );
endinterface

// File: rtl/arm_cond_check.sv
// ARM condition-code evaluation against registered NZCV; 1111 never executes.
module arm_cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ex
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Moore FSM sequencing the multicycle ARM-subset datapath; owns the NZCV flags.
module arm_multicycle_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  arm_multicycle_ctrl_if.master        bus
);
  state_t     state;
  logic [3:0] flags;
  logic       cond_ex;

  logic [1:0] op;
  logic [3:0] cmd;
  logic       i_bit, s_bit, l_bit, u_bit, supported, is_cmp;
  assign op     = bus.instr[27:26];
  assign i_bit  = bus.instr[25];
  assign cmd    = bus.instr[24:21];
  assign u_bit  = bus.instr[23];
  assign s_bit  = bus.instr[20];
  assign l_bit  = (op == OP_BR) ? bus.instr[24] : bus.instr[20];
  assign is_cmp = (cmd == CMD_CMP);

  // Memory ops only support the immediate-offset form (bit 25 clear).
  always_comb begin
    case (op)
      OP_DP:   supported = cmd_supported(cmd);
      OP_MEM:  supported = ~i_bit;
      OP_BR:   supported = 1'b1;
      default: supported = 1'b0;
    endcase
  end

  arm_cond_check u_cond (.cond(bus.instr[31:28]), .nzcv(flags), .cond_ex(cond_ex));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      flags <= RESET_FLAGS;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (!cond_ex || !supported) state <= S_FETCH;
          else case (op)
            OP_MEM:  state <= S_MEMADR;
            OP_DP:   state <= i_bit ? S_EXECI : S_EXECR;
            default: state <= l_bit ? S_LINK : S_BRANCH;
          endcase
        end
        S_EXECR, S_EXECI: begin
          if (s_bit || is_cmp)
            flags <= cmd_is_logic(cmd) ? {bus.alu_flags[3:2], flags[1:0]} : bus.alu_flags;
          state <= is_cmp ? S_FETCH : S_ALUWB;
        end
        S_MEMADR: state <= l_bit ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state <= S_MEMWB;
        S_LINK:   state <= S_BRANCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  logic    pc_we, ir_we, mem_we, reg_we;
  alu_op_t alu_op;

  always_comb begin
    pc_we = 1'b0; ir_we = 1'b0; mem_we = 1'b0; reg_we = 1'b0;
    bus.link        = 1'b0;
    bus.adr_src     = 1'b0;
    bus.result_src  = RES_ALUOUT;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = SRCB_RM;
    bus.imm_src     = IMM8;
    bus.reg_src     = 2'b00;
    alu_op          = ALU_ADD;
    case (state)
      S_FETCH: begin
        ir_we = 1'b1; pc_we = 1'b1;
        bus.alu_src_a = 1'b1; bus.alu_src_b = SRCB_4; bus.result_src = RES_ALURES;
      end
      S_DECODE: begin
        // PC+4 here is what the datapath presents as R15 (instr addr + 8).
        bus.alu_src_a = 1'b1; bus.alu_src_b = SRCB_4;
        bus.imm_src = (op == OP_MEM) ? IMM12 : (op == OP_BR) ? IMM24 : IMM8;
      end
      S_EXECR: alu_op = cmd_alu_op(cmd);
      S_EXECI: begin
        bus.alu_src_b = SRCB_IMM; alu_op = cmd_alu_op(cmd);
      end
      S_ALUWB: reg_we = 1'b1;
      S_MEMADR: begin
        bus.alu_src_b = SRCB_IMM; bus.imm_src = IMM12;
        alu_op = u_bit ? ALU_ADD : ALU_SUB;
        bus.reg_src[1] = ~l_bit;
      end
      S_MEMRD: bus.adr_src = 1'b1;
      S_MEMWB: begin
        bus.result_src = RES_DATA; reg_we = 1'b1;
      end
      S_MEMWR: begin
        bus.adr_src = 1'b1; mem_we = 1'b1; bus.reg_src[1] = 1'b1;
      end
      S_LINK: begin
        bus.result_src = RES_PC; reg_we = 1'b1; bus.link = 1'b1; bus.imm_src = IMM24;
      end
      S_BRANCH: begin
        bus.reg_src[0] = 1'b1; bus.alu_src_b = SRCB_IMM; bus.imm_src = IMM24;
        bus.result_src = RES_ALURES; pc_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset idles in FETCH, so enables must be masked while rst_n is low.
  assign bus.pc_write    = pc_we  & rst_n;
  assign bus.ir_write    = ir_we  & rst_n;
  assign bus.mem_write   = mem_we & rst_n;
  assign bus.reg_write   = reg_we & rst_n;
  assign bus.alu_control = alu_op;
  assign bus.state_o     = state;
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed bench for arm_multicycle_ctrl: walks instruction sequences cycle by cycle.
module tb_arm_multicycle_ctrl;
  import arm_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  arm_multicycle_ctrl_if ctl();
  arm_multicycle_ctrl #(.RESET_FLAGS(4'b0000)) dut (.clk(clk), .rst_n(rst_n), .bus(ctl));

  always #5 clk = ~clk;

  // select vector: [12] adr_src [11:10] result_src [9] a [8:7] b [6:4] alu [3:2] imm [1:0] reg_src
  localparam logic [12:0] MA = 13'h1000, MR = 13'h0c00, MSA = 13'h0200, MSB = 13'h0180,
                          MAL = 13'h0070, MI = 13'h000c, MRG = 13'h0003;

  function automatic logic [12:0] sv(input logic adr, input logic [1:0] rs, input logic a,
                                     input logic [1:0] b, input logic [2:0] alu,
                                     input logic [1:0] imm, input logic [1:0] rsrc);
    return {adr, rs, a, b, alu, imm, rsrc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // we = {pc_write, ir_write, mem_write, reg_write, link}
  task automatic cyc(input string tag, input state_t st, input logic [4:0] we,
                     input logic [12:0] sel, input logic [12:0] msk);
    logic [12:0] obs;
    #1;
    obs = {ctl.adr_src, ctl.result_src, ctl.alu_src_a, ctl.alu_src_b, ctl.alu_control,
           ctl.imm_src, ctl.reg_src};
    chk({tag, ".state"}, 32'(ctl.state_o), 32'(st));
    chk({tag, ".we"}, 32'({ctl.pc_write, ctl.ir_write, ctl.mem_write, ctl.reg_write, ctl.link}),
        32'(we));
    chk({tag, ".sel"}, 32'(obs & msk), 32'(sel & msk));
    @(negedge clk);
  endtask

  task automatic fetch(input string tag, input logic [31:0] ins);
    ctl.instr = ins;
    cyc({tag, ".F"}, S_FETCH, 5'b11000, sv(0, 2'b10, 1, 2'b10, 3'b000, 2'b00, 2'b00),
        MA | MR | MSA | MSB | MAL | MRG);
  endtask
  task automatic decode(input string tag, input logic [1:0] imm);
    cyc({tag, ".D"}, S_DECODE, 5'b00000, sv(0, 0, 1, 2'b10, 3'b000, imm, 0), MSA | MSB | MAL | MI);
  endtask
  task automatic execi(input string tag, input logic [2:0] alu);
    cyc({tag, ".EI"}, S_EXECI, 5'b00000, sv(0, 0, 0, 2'b01, alu, 2'b00, 0), MSA | MSB | MAL | MI);
  endtask
  task automatic execr(input string tag, input logic [2:0] alu, input logic [3:0] fl);
    ctl.alu_flags = fl;
    cyc({tag, ".ER"}, S_EXECR, 5'b00000, sv(0, 0, 0, 2'b00, alu, 0, 0), MSA | MSB | MAL);
    ctl.alu_flags = 4'hf;
  endtask
  task automatic aluwb(input string tag);
    cyc({tag, ".WB"}, S_ALUWB, 5'b00010, sv(0, 2'b00, 0, 0, 0, 0, 0), MR);
  endtask
  // Data-processing immediate add: full 4-cycle run or 2-cycle skip.
  task automatic addi(input string tag, input logic [31:0] ins, input logic runs);
    fetch(tag, ins);
    decode(tag, 2'b00);
    if (runs) begin
      execi(tag, 3'b000);
      aluwb(tag);
    end
  endtask
  task automatic memadr(input string tag, input logic [2:0] alu, input logic [1:0] rsrc);
    cyc({tag, ".MA"}, S_MEMADR, 5'b00000, sv(0, 0, 0, 2'b01, alu, 2'b01, rsrc),
        MSA | MSB | MAL | MI | MRG);
  endtask

  initial begin
    ctl.instr = 32'h0;
    ctl.alu_flags = 4'hf;
    @(negedge clk);
    #1;
    chk("rst.state", 32'(ctl.state_o), 32'(S_FETCH));
    chk("rst.we", 32'({ctl.pc_write, ctl.ir_write, ctl.mem_write, ctl.reg_write}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flags come out of reset as 0000: EQ skips, NE runs.
    addi("addeq0", 32'h02821005, 1'b0);
    addi("addne0", 32'h12821005, 1'b1);
    addi("add", 32'he2821005, 1'b1);

    // CMP R0,R0 -> NZCV 0110
    fetch("cmp", 32'he1500000); decode("cmp", 2'b00); execr("cmp", 3'b001, 4'b0110);
    addi("addeq1", 32'h02821005, 1'b1);
    addi("addne1", 32'h12821005, 1'b0);
    addi("addcs", 32'h22821005, 1'b1);

    // ANDS with ALU NZCV 1001 -> flags 1010 (C, V held)
    fetch("ands", 32'he0121003); decode("ands", 2'b00); execr("ands", 3'b010, 4'b1001);
    aluwb("ands");
    addi("addmi", 32'h42821005, 1'b1);
    addi("addcc", 32'h32821005, 1'b0);
    addi("addvs", 32'h62821005, 1'b0);
    addi("addeq2", 32'h02821005, 1'b0);
    addi("addnv", 32'hf2821005, 1'b0);

    // LDR R3,[R4,#-8]
    fetch("ldr", 32'he5143008); decode("ldr", 2'b01); memadr("ldr", 3'b001, 2'b00);
    cyc("ldr.MR", S_MEMRD, 5'b00000, sv(1, 2'b00, 0, 0, 0, 0, 0), MA | MR);
    cyc("ldr.MW", S_MEMWB, 5'b00010, sv(0, 2'b01, 0, 0, 0, 0, 0), MR);

    // STR R3,[R4,#4]
    fetch("str", 32'he5843004); decode("str", 2'b01); memadr("str", 3'b000, 2'b10);
    cyc("str.WR", S_MEMWR, 5'b00100, sv(1, 2'b00, 0, 0, 0, 0, 2'b10), MA | MR | MRG);

    // BL #2 then B #2
    fetch("bl", 32'heb000002); decode("bl", 2'b10);
    cyc("bl.LK", S_LINK, 5'b00011, sv(0, 2'b11, 0, 0, 0, 0, 0), MR);
    cyc("bl.BR", S_BRANCH, 5'b10000, sv(0, 2'b10, 0, 2'b01, 3'b000, 2'b10, 2'b01),
        MR | MSA | MSB | MAL | MI | MRG);
    fetch("b", 32'hea000002); decode("b", 2'b10);
    cyc("b.BR", S_BRANCH, 5'b10000, sv(0, 2'b10, 0, 2'b01, 3'b000, 2'b10, 2'b01),
        MR | MSA | MSB | MAL | MI | MRG);

    // Unsupported cmd 0001 is a 2-cycle NOP; MOV uses pass-B.
    fetch("eor", 32'he0221003); decode("eor", 2'b00);
    fetch("mov", 32'he3a01005); decode("mov", 2'b00); execi("mov", 3'b100); aluwb("mov");

    // Set Z=1, then reset in the middle of a store.
    fetch("cmp2", 32'he1500000); decode("cmp2", 2'b00); execr("cmp2", 3'b001, 4'b0110);
    fetch("strr", 32'he5843004); decode("strr", 2'b01); memadr("strr", 3'b000, 2'b10);
    #1;
    chk("strr.WR.state", 32'(ctl.state_o), 32'(S_MEMWR));
    chk("strr.WR.mem_write", 32'(ctl.mem_write), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("strr.rst.mem_write", 32'(ctl.mem_write), 32'h0);
    chk("strr.rst.state", 32'(ctl.state_o), 32'(S_FETCH));
    chk("strr.rst.we", 32'({ctl.pc_write, ctl.ir_write, ctl.reg_write}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // Z is back to 0 after reset, so ADDEQ skips.
    addi("addeq3", 32'h02821005, 1'b0);
    fetch("end", 32'he2821005);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
